e3_div: RTL and testbench
=========================

Name: e3_div

Overview:
Sequential divider, the inverse of the team's Excess-3 multiplier.
- Input: a two-digit Excess-3 dividend (0..99) and a one-digit Excess-3 divisor (0..9).
- Output: a two-digit Excess-3 quotient and a one-digit Excess-3 remainder.
- Uses restoring shift-subtract division, one quotient bit per cycle.
- Valid/ready handshakes on both the input and output sides; sits downstream of BCD/E3 arithmetic units.

Parameters:
- BIAS, 3, Excess-3 code offset added/removed per digit.
- DIV_W, 7, binary width of dividend/quotient (covers 0..99); fixes DIV-state iteration count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- dividend  in  8  E3 tens digit [7:4], E3 units digit [3:0].
- divisor  in  4  E3 digit.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  8  E3 tens [7:4], E3 units [3:0].
- remainder  out  4  E3 digit.
- err  out  1  divide-by-zero (or invalid code, see Optional Feature).

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE, in_ready=1, out_valid=0, quotient=8'h33, remainder=4'h3, err=0.
- Internal registers are cleared.
- Reset mid-operation abandons the operation with no output.

States:
- IDLE: in_ready=1. On in_valid&&in_ready, latch operands and go to CONV.
- CONV (1 cycle):
  - bin_dvd = (tens-BIAS)*10 + (units-BIAS); bin_dvs = divisor-BIAS.
  - If bin_dvs==0 (or an error is flagged by the Optional Feature), go to DONE with err=1, quotient=8'h33, remainder=4'h3.
  - Otherwise clear the partial remainder and go to DIV.
- DIV (exactly DIV_W=7 cycles): per cycle:
  - Shift the next dividend MSB into the partial remainder.
  - Subtract bin_dvs if partial remainder >= bin_dvs, recording the quotient bit.
  - A 3-bit iteration counter counts up; leave after the 7th iteration.
- DONE:
  - out_valid=1; quotient/remainder registered in E3: digits = q/10+BIAS, q%10+BIAS, r+BIAS.
  - On out_ready, go to IDLE (out_valid drops next cycle).

Timing and handshake rules:
- Latency, counting the acceptance edge as cycle 0: out_valid high from cycle 9 normally, from cycle 2 on error.
- in_ready is low in CONV/DIV/DONE. A new operand cannot be accepted in the same cycle a result is consumed.
- Operand changes after acceptance are ignored.
- quotient/remainder/err are stable while out_valid=1 and hold after the handshake until the next result.
- out_ready while out_valid=0 is ignored.

Widths:
- Partial remainder is 4 bits plus 1 guard bit.
- Quotient is at most 99, so it fits DIV_W bits.
- Remainder is < 9, so one digit.

Optional Feature:
Macro E3_DIV_CHECK_EN.
- Defined: CONV flags err=1 if any input digit is outside 4'b0011..4'b1100; the path then goes straight to DONE like divide-by-zero.
- Undefined: no code check. Out-of-range codes produce a deterministic but meaningless result with err=0. Divide-by-zero is always flagged.

Decomposition:
- Package e3_pkg:
  - E3_BIAS=3, E3_ZERO=4'h3, E3_MIN=4'h3, E3_MAX=4'hC.
  - state typedef {IDLE, CONV, DIV, DONE}.
- One sub-module, e3_bin2e3: combinational binary 0..99 to two E3 digits; used for quotient and remainder output encoding.

Test Plan:
1. Reset: rst_n low → in_ready=1, out_valid=0, quotient=8'h33, remainder=4'h3, err=0.
2. 99/7: dividend=1100_1100, divisor=1010 → out_valid at cycle 9, quotient=0100_0111 (14), remainder=0100 (1), err=0.
3. 45/9 and 0/5:
   - 45/9: dividend=0111_1000, divisor=1100 → quotient=0011_1000 (05), remainder=0011 (0).
   - 0/5: dividend=0011_0011, divisor=1000 → quotient=8'h33, remainder=4'h3.
4. Divide by zero: dividend=1010_0011 (70), divisor=0011 → err=1 at cycle 2, quotient=8'h33, remainder=4'h3.
5. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0; release → IDLE next cycle.
   - Assert rst_n low during DIV → immediate IDLE, no out_valid.
6. E3_DIV_CHECK_EN defined: divisor=1111 → err=1. Undefined: err=0.

Source files
------------

// File: rtl/e3_div_pkg.sv
// Shared constants and state encoding for the Excess-3 divider.
package e3_pkg;

    localparam int          E3_BIAS = 3;
    localparam logic [3:0]  E3_ZERO = 4'h3;
    localparam logic [3:0]  E3_MIN  = 4'h3;
    localparam logic [3:0]  E3_MAX  = 4'hC;

    // FSM state type with fixed constant encodings
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CONV = 2'd1;
    localparam state_t DIV  = 2'd2;
    localparam state_t DONE = 2'd3;

    // True when a 4-bit code is a legal Excess-3 digit (0..9)
    function automatic logic e3_digit_ok(input logic [3:0] code);
        return (code >= E3_MIN) && (code <= E3_MAX);
    endfunction

endpackage

// File: rtl/e3_div_if.sv
// Operand/result handshake bundle for the Excess-3 divider.
interface e3_div_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, err
    );

endinterface

// File: rtl/e3_div_bin2e3.sv
// Combinational binary (0..99) to two Excess-3 digits {tens, units}.
module e3_bin2e3 #(
    parameter int BIAS = 3
) (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [6:0] tens_bin;
    logic [6:0] units_bin;

    // Split into decimal digits, then add the code offset to each
    always_comb begin
        tens_bin  = bin / 7'd10;
        units_bin = bin % 7'd10;
        tens      = 4'(tens_bin  + 7'(BIAS));
        units     = 4'(units_bin + 7'(BIAS));
    end

endmodule

// File: rtl/e3_div.sv
// Sequential restoring divider for Excess-3 operands: two-digit dividend,
// one-digit divisor, two-digit quotient and one-digit remainder.
// Optional input-code checking is enabled by defining E3_DIV_CHECK_EN.
module e3_div
    import e3_pkg::*;
#(
    parameter int BIAS  = E3_BIAS,
    parameter int DIV_W = 7
) (
    input  logic     clk,
    input  logic     rst_n,
    e3_div_if.slave  bus
);

    localparam logic [2:0] LAST_ITER = 3'(DIV_W - 1);

    state_t             state;
    logic [7:0]         op_dvd;
    logic [3:0]         op_dvs;
    logic [DIV_W-1:0]   dvd_q;      // dividend bits shift out, quotient bits shift in
    logic [3:0]         dvs_bin;
    logic [4:0]         prem;       // partial remainder with guard bit
    logic [2:0]         iter;
    logic               out_valid;
    logic [7:0]         quotient;
    logic [3:0]         remainder;
    logic               err;

    logic [DIV_W-1:0]   dvd_conv;
    logic [3:0]         dvs_conv;
    logic               code_bad;
    logic [4:0]         prem_sh;
    logic               take;
    logic [4:0]         prem_nx;
    logic [DIV_W-1:0]   q_nx;
    logic [3:0]         q_tens;
    logic [3:0]         q_units;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic [3:0]         r_digit;

    // Excess-3 dividend to binary; illegal codes simply wrap
    function automatic logic [DIV_W-1:0] dvd_to_bin(input logic [7:0] code);
        logic [7:0] t;
        logic [7:0] u;
        t = {4'b0, code[7:4]} - 8'(BIAS);
        u = {4'b0, code[3:0]} - 8'(BIAS);
        return DIV_W'(8'(t * 8'd10) + u);
    endfunction

    // Operand conversion and optional code check for the CONV state
    always_comb begin
        dvd_conv = dvd_to_bin(op_dvd);
        dvs_conv = 4'(op_dvs - 4'(BIAS));
`ifdef E3_DIV_CHECK_EN
        code_bad = !e3_digit_ok(op_dvd[7:4]) || !e3_digit_ok(op_dvd[3:0]) ||
                   !e3_digit_ok(op_dvs);
`else
        code_bad = 1'b0;
`endif
    end

    // One restoring shift-subtract step
    always_comb begin
        prem_sh = {prem[3:0], dvd_q[DIV_W-1]};
        take    = prem_sh >= {1'b0, dvs_bin};
        prem_nx = take ? (prem_sh - {1'b0, dvs_bin}) : prem_sh;
        q_nx    = {dvd_q[DIV_W-2:0], take};
    end

    e3_bin2e3 #(.BIAS(BIAS)) u_q_enc (
        .bin   (q_nx),
        .tens  (q_tens),
        .units (q_units)
    );

    e3_bin2e3 #(.BIAS(BIAS)) u_r_enc (
        .bin   (7'(prem_nx)),
        .tens  (r_tens),
        .units (r_units)
    );

    // Remainders above 9 only arise from illegal codes; pin them to the top digit
    always_comb begin
        r_digit = (r_tens == E3_ZERO) ? r_units : E3_MAX;
    end

    // Control FSM, datapath registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_dvd    <= '0;
            op_dvs    <= '0;
            dvd_q     <= '0;
            dvs_bin   <= '0;
            prem      <= '0;
            iter      <= '0;
            out_valid <= 1'b0;
            quotient  <= {E3_ZERO, E3_ZERO};
            remainder <= E3_ZERO;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_dvd <= bus.dividend;
                        op_dvs <= bus.divisor;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    dvd_q   <= dvd_conv;
                    dvs_bin <= dvs_conv;
                    prem    <= '0;
                    iter    <= '0;
                    if ((dvs_conv == 4'd0) || code_bad) begin
                        err       <= 1'b1;
                        quotient  <= {E3_ZERO, E3_ZERO};
                        remainder <= E3_ZERO;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    prem  <= prem_nx;
                    dvd_q <= q_nx;
                    iter  <= iter + 3'd1;
                    if (iter == LAST_ITER) begin
                        quotient  <= {q_tens, q_units};
                        remainder <= r_digit;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid;
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.err       = err;

endmodule

// File: tb/tb_e3_div.sv
// Directed bench for e3_div: latency, results, errors, backpressure, reset.
module tb_e3_div;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    e3_div_if bus ();

    e3_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one operation, measure latency, check results, then consume it
    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                          input int exp_lat, input logic chk_data,
                          input logic [7:0] exp_q, input logic [3:0] exp_r, input logic exp_err);
        int cnt;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 8'hFF;
        bus.divisor  = 4'h0;
        @(negedge clk);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(cnt + 1), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        if (chk_data) begin
            check({tag, "_q"}, 32'(bus.quotient), 32'(exp_q));
            check({tag, "_r"}, 32'(bus.remainder), 32'(exp_r));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
        if (chk_data) check({tag, "_hold_q"}, 32'(bus.quotient), 32'(exp_q));
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = 8'h33;
        bus.divisor   = 4'h4;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'h33);
        check("rst_r", 32'(bus.remainder), 32'h3);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;

        run_op("d99_7",  8'hCC, 4'hA, 9, 1'b1, 8'h47, 4'h4, 1'b0);
        run_op("d45_9",  8'h78, 4'hC, 9, 1'b1, 8'h38, 4'h3, 1'b0);
        run_op("d0_5",   8'h33, 4'h8, 9, 1'b1, 8'h33, 4'h3, 1'b0);
        run_op("d70_0",  8'hA3, 4'h3, 2, 1'b1, 8'h33, 4'h3, 1'b1);
        run_op("d99_1",  8'hCC, 4'h4, 9, 1'b1, 8'hCC, 4'h3, 1'b0);
        run_op("d50_3",  8'h83, 4'h6, 9, 1'b1, 8'h49, 4'h5, 1'b0);
        run_op("d9_9",   8'h3C, 4'hC, 9, 1'b1, 8'h34, 4'h3, 1'b0);
`ifdef E3_DIV_CHECK_EN
        run_op("bad_dvs", 8'h44, 4'hF, 2, 1'b1, 8'h33, 4'h3, 1'b1);
`else
        run_op("bad_dvs", 8'h44, 4'hF, 9, 1'b0, 8'h00, 4'h0, 1'b0);
`endif

        // Backpressure: 45/9 held for five cycles before the consumer takes it
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 8'h78;
        bus.divisor  = 4'hC;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_q", 32'(bus.quotient), 32'h38);
            check("bp_r", 32'(bus.remainder), 32'h3);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_idle", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of DIV abandons the operation
        bus.in_valid = 1'b1;
        bus.dividend = 8'hCC;
        bus.divisor  = 4'hA;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_q", 32'(bus.quotient), 32'h33);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("mid_rst_no_out", 32'(bus.out_valid), 32'd0);
        check("mid_rst_idle", 32'(bus.in_ready), 32'd1);

        run_op("after_rst", 8'h78, 4'hC, 9, 1'b1, 8'h38, 4'h3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
